// File: rtl/ycc_rgb_conv_pipe_pkg.sv
// Shared types and constants for the YCbCr-to-RGB pipeline: range modes,
// colour-matrix coefficients and the offsets applied to the incoming samples.
package ycc_rgb_pkg;

    typedef enum logic {
        YCC_JFIF  = 1'b0,
        YCC_BT601 = 1'b1
    } ycc_mode_e;

    typedef enum logic [2:0] {
        K_YY,
        K_R_CR,
        K_G_CB,
        K_G_CR,
        K_B_CB
    } ycc_coef_e;

    localparam real JFIF_YY    = 1.0;
    localparam real JFIF_R_CR  = 1.402;
    localparam real JFIF_G_CB  = 0.344136;
    localparam real JFIF_G_CR  = 0.714136;
    localparam real JFIF_B_CB  = 1.772;

    localparam real BT601_YY   = 1.164383;
    localparam real BT601_R_CR = 1.596027;
    localparam real BT601_G_CB = 0.391762;
    localparam real BT601_G_CR = 0.812968;
    localparam real BT601_B_CB = 2.017232;

    // Studio-range black level at 8 bits; it scales with the sample width.
    localparam int LUMA_OFS_8 = 16;

    function automatic int chroma_ofs(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    function automatic int luma_ofs(input int data_w);
        return LUMA_OFS_8 << (data_w - 8);
    endfunction

    function automatic int coef_k(input ycc_mode_e mode, input ycc_coef_e sel, input int frac_w);
        real c;
        c = 0.0;
        if (mode == YCC_JFIF) begin
            case (sel)
                K_YY:    c = JFIF_YY;
                K_R_CR:  c = JFIF_R_CR;
                K_G_CB:  c = JFIF_G_CB;
                K_G_CR:  c = JFIF_G_CR;
                K_B_CB:  c = JFIF_B_CB;
                default: c = 0.0;
            endcase
        end else begin
            case (sel)
                K_YY:    c = BT601_YY;
                K_R_CR:  c = BT601_R_CR;
                K_G_CB:  c = BT601_G_CB;
                K_G_CR:  c = BT601_G_CR;
                K_B_CB:  c = BT601_B_CB;
                default: c = 0.0;
            endcase
        end
        // All coefficients are positive, so adding one half then truncating rounds to nearest.
        return $rtoi(c * real'(longint'(1) << frac_w) + 0.5);
    endfunction

endpackage

// File: rtl/ycc_rgb_conv_pipe_if.sv
// Valid/ready stream bundle carrying YCbCr beats in and RGB beats out.
interface ycc_rgb_conv_pipe_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_y;
    logic [DATA_W-1:0] in_cb;
    logic [DATA_W-1:0] in_cr;
    logic              in_mode;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] out_g;
    logic [DATA_W-1:0] out_b;
    logic              out_last;

    modport slave (
        input  in_valid, in_y, in_cb, in_cr, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b, out_last
    );

    modport master (
        output in_valid, in_y, in_cb, in_cr, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b, out_last
    );
endinterface

// File: rtl/ycc_rgb_conv_pipe_round_sat.sv
// Fixed-point sum to pixel: round half-up, drop fraction bits, clamp to [0, 2^DATA_W-1].
module ycc_round_sat #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 14,
    parameter int ACC_W  = DATA_W + FRAC_W + 5
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic        [DATA_W-1:0] pix_o
);
    localparam longint HALF_L = longint'(1) << (FRAC_W - 1);
    localparam longint MAX_L  = (longint'(1) << DATA_W) - 1;

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(HALF_L);
    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX_L);

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] rnd;

    assign biased = sum_i + HALF;
    assign rnd    = biased >>> FRAC_W;

    always_comb begin
        pix_o = rnd[DATA_W-1:0];
        if (rnd[ACC_W-1]) begin
            pix_o = '0;
        end else if (rnd > MAX_S) begin
            pix_o = '1;
        end
    end
endmodule

// File: rtl/ycc_rgb_conv_pipe.sv
// Three-stage YCbCr-to-RGB converter: S1 removes offsets, S2 forms the matrix
// products, S3 sums, rounds and clamps. Elastic valid/ready with collapsing bubbles.
module ycc_rgb_conv_pipe
    import ycc_rgb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 14
) (
    input logic               clk,
    input logic               rst,
    ycc_rgb_conv_pipe_if.slave bus
);
    localparam int DW1   = DATA_W + 1;
    localparam int ACC_W = DATA_W + FRAC_W + 5;

    localparam logic [DATA_W-1:0] C_OFS = DATA_W'(chroma_ofs(DATA_W));
    localparam logic [DATA_W-1:0] Y_OFS = DATA_W'(luma_ofs(DATA_W));

    localparam int KJ_YY = coef_k(YCC_JFIF,  K_YY,   FRAC_W);
    localparam int KJ_RC = coef_k(YCC_JFIF,  K_R_CR, FRAC_W);
    localparam int KJ_GB = coef_k(YCC_JFIF,  K_G_CB, FRAC_W);
    localparam int KJ_GC = coef_k(YCC_JFIF,  K_G_CR, FRAC_W);
    localparam int KJ_BB = coef_k(YCC_JFIF,  K_B_CB, FRAC_W);
    localparam int KS_YY = coef_k(YCC_BT601, K_YY,   FRAC_W);
    localparam int KS_RC = coef_k(YCC_BT601, K_R_CR, FRAC_W);
    localparam int KS_GB = coef_k(YCC_BT601, K_G_CB, FRAC_W);
    localparam int KS_GC = coef_k(YCC_BT601, K_G_CR, FRAC_W);
    localparam int KS_BB = coef_k(YCC_BT601, K_B_CB, FRAC_W);

    // Stage registers
    logic                     v1_q, v2_q, v3_q;
    logic                     v1_d, v2_d, v3_d;
    logic signed [DW1-1:0]    yd1_q, cbd1_q, crd1_q;
    ycc_mode_e                mode1_q;
    logic                     last1_q, last2_q, last3_q;
    logic signed [ACC_W-1:0]  py2_q, prc2_q, pgb2_q, pgr2_q, pbb2_q;
    logic [DATA_W-1:0]        pix3_q [3];

    // Handshake: each stage advances when empty or when the stage after it advances.
    logic adv1, adv2, adv3;

    always_comb begin
        adv3 = !v3_q || bus.out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
        v1_d = adv1 ? bus.in_valid : v1_q;
        v2_d = adv2 ? v1_q         : v2_q;
        v3_d = adv3 ? v2_q         : v3_q;
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3_q;
    assign bus.out_r     = pix3_q[0];
    assign bus.out_g     = pix3_q[1];
    assign bus.out_b     = pix3_q[2];
    assign bus.out_last  = last3_q;

    // S1 next-state: offset removal
    ycc_mode_e             mode_in;
    logic signed [DW1-1:0] yd_d, cbd_d, crd_d;

    assign mode_in = ycc_mode_e'(bus.in_mode);

    always_comb begin
        cbd_d = $signed({1'b0, bus.in_cb}) - $signed({1'b0, C_OFS});
        crd_d = $signed({1'b0, bus.in_cr}) - $signed({1'b0, C_OFS});
        yd_d  = $signed({1'b0, bus.in_y});
        if (mode_in == YCC_BT601) begin
            yd_d = $signed({1'b0, bus.in_y}) - $signed({1'b0, Y_OFS});
        end
    end

    // S2 next-state: products with per-beat coefficients
    logic signed [ACC_W-1:0] k_yy, k_rc, k_gb, k_gc, k_bb;
    logic signed [ACC_W-1:0] py_d, prc_d, pgb_d, pgr_d, pbb_d;

    always_comb begin
        k_yy = ACC_W'(KJ_YY);
        k_rc = ACC_W'(KJ_RC);
        k_gb = ACC_W'(KJ_GB);
        k_gc = ACC_W'(KJ_GC);
        k_bb = ACC_W'(KJ_BB);
        if (mode1_q == YCC_BT601) begin
            k_yy = ACC_W'(KS_YY);
            k_rc = ACC_W'(KS_RC);
            k_gb = ACC_W'(KS_GB);
            k_gc = ACC_W'(KS_GC);
            k_bb = ACC_W'(KS_BB);
        end
        py_d  = ACC_W'(yd1_q)  * k_yy;
        prc_d = ACC_W'(crd1_q) * k_rc;
        pgb_d = ACC_W'(cbd1_q) * k_gb;
        pgr_d = ACC_W'(crd1_q) * k_gc;
        pbb_d = ACC_W'(cbd1_q) * k_bb;
    end

    // S3 next-state: channel sums (R, G, B) then round/saturate
    logic signed [ACC_W-1:0] sum_s3 [3];
    logic [DATA_W-1:0]       pix_d  [3];

    always_comb begin
        sum_s3[0] = py2_q + prc2_q;
        sum_s3[1] = py2_q - pgb2_q - pgr2_q;
        sum_s3[2] = py2_q + pbb2_q;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rs
        ycc_round_sat #(
            .DATA_W(DATA_W),
            .FRAC_W(FRAC_W),
            .ACC_W (ACC_W)
        ) u_round_sat (
            .sum_i(sum_s3[gi]),
            .pix_o(pix_d[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            yd1_q   <= '0;
            cbd1_q  <= '0;
            crd1_q  <= '0;
            mode1_q <= YCC_JFIF;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
            py2_q   <= '0;
            prc2_q  <= '0;
            pgb2_q  <= '0;
            pgr2_q  <= '0;
            pbb2_q  <= '0;
            for (int i = 0; i < 3; i++) pix3_q[i] <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (adv1 && bus.in_valid) begin
                yd1_q   <= yd_d;
                cbd1_q  <= cbd_d;
                crd1_q  <= crd_d;
                mode1_q <= mode_in;
                last1_q <= bus.in_last;
            end
            if (adv2 && v1_q) begin
                py2_q   <= py_d;
                prc2_q  <= prc_d;
                pgb2_q  <= pgb_d;
                pgr2_q  <= pgr_d;
                pbb2_q  <= pbb_d;
                last2_q <= last1_q;
            end
            // Output registers only move on a real transfer, so they hold while stalled.
            if (adv3 && v2_q) begin
                for (int i = 0; i < 3; i++) pix3_q[i] <= pix_d[i];
                last3_q <= last2_q;
            end
        end
    end
endmodule

// File: tb/tb_ycc_rgb_conv_pipe.sv
// Scoreboard bench for ycc_rgb_conv_pipe: accepted beats are modelled with real-valued
// colour maths and checked in order as they leave the converter.
module tb_ycc_rgb_conv_pipe;

    localparam int DW = 8;
    localparam int FW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ycc_rgb_conv_pipe_if #(.DATA_W(DW)) bus ();

    ycc_rgb_conv_pipe #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int r, g, b, last;
        int y, cb, cr, mode;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   or_mode  = 0;  // 0: always ready, 1: random, 2: never ready
    bit   check_lat = 1'b0;
    int   n_out    = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Rounded fixed-point coefficient, then a real-valued round-half-up and clamp.
    function automatic longint kq(input real c);
        return longint'($floor(c * 16384.0 + 0.5));
    endfunction

    function automatic int to_pix(input longint s);
        real v;
        v = $floor((real'(s) + 8192.0) / 16384.0);
        if (v < 0.0) return 0;
        if (v > 255.0) return 255;
        return int'(v);
    endfunction

    function automatic exp_t model(input int y, input int cb, input int cr, input int mode, input int last);
        exp_t   e;
        longint kyy, krc, kgb, kgc, kbb, yd, cbd, crd;
        if (mode != 0) begin
            kyy = kq(1.164383); krc = kq(1.596027); kgb = kq(0.391762);
            kgc = kq(0.812968); kbb = kq(2.017232);
            yd  = y - 16;
        end else begin
            kyy = kq(1.0); krc = kq(1.402); kgb = kq(0.344136);
            kgc = kq(0.714136); kbb = kq(1.772);
            yd  = y;
        end
        cbd    = cb - 128;
        crd    = cr - 128;
        e.r    = to_pix(yd * kyy + crd * krc);
        e.g    = to_pix(yd * kyy - cbd * kgb - crd * kgc);
        e.b    = to_pix(yd * kyy + cbd * kbb);
        e.last = last;
        e.y = y; e.cb = cb; e.cr = cr; e.mode = mode;
        e.acc  = cyc;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshake rule, output hold, latency, in-order value checks, acceptance capture.
    initial begin
        bit     prev_stall = 1'b0;
        bit     head_chk   = 1'b0;
        longint prev_vec   = 0;
        longint cur_vec;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
                head_chk   = 1'b0;
                continue;
            end
            cur_vec = {bus.out_valid, bus.out_r, bus.out_g, bus.out_b, bus.out_last};
            chk("in_ready", longint'(bus.in_ready), longint'(!(sb.size() >= 3 && !bus.out_ready)));
            if (prev_stall) chk("hold", cur_vec, prev_vec);
            if (bus.out_valid) begin
                if (check_lat && !head_chk && sb.size() > 0) begin
                    chk("latency", longint'(cyc - sb[0].acc), 3);
                    head_chk = 1'b1;
                end
                if (bus.out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL spurious_out: got rgb=%0d,%0d,%0d, expected no beat",
                                 bus.out_r, bus.out_g, bus.out_b);
                    end else begin
                        e = sb.pop_front();
                        n_out++;
                        if (bus.out_r != 8'(e.r) || bus.out_g != 8'(e.g) || bus.out_b != 8'(e.b) ||
                            bus.out_last != 1'(e.last)) begin
                            n_fail++;
                            $display("FAIL pixel %0d: y=%0d cb=%0d cr=%0d m=%0d got rgb=%0d,%0d,%0d last=%0d, expected %0d,%0d,%0d last=%0d",
                                     n_out, e.y, e.cb, e.cr, e.mode, bus.out_r, bus.out_g, bus.out_b,
                                     bus.out_last, e.r, e.g, e.b, e.last);
                        end else begin
                            $display("beat %0d: y=%0d cb=%0d cr=%0d m=%0d -> rgb=%0d,%0d,%0d last=%0d ok",
                                     n_out, e.y, e.cb, e.cr, e.mode, e.r, e.g, e.b, e.last);
                        end
                    end
                    head_chk = 1'b0;
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(int'(bus.in_y), int'(bus.in_cb), int'(bus.in_cr),
                                   int'(bus.in_mode), int'(bus.in_last)));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_vec   = cur_vec;
        end
    end

    // Drivers assume they are entered just after a rising edge.
    task automatic send(input int y, input int cb, input int cr, input int mode, input int last);
        bit done;
        done = 1'b0;
        bus.in_y     = 8'(y);
        bus.in_cb    = 8'(cb);
        bus.in_cr    = 8'(cr);
        bus.in_mode  = 1'(mode);
        bus.in_last  = 1'(last);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        chk("drain", longint'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_y = '0; bus.in_cb = '0; bus.in_cr = '0;
        bus.in_mode = 1'b0; bus.in_last = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_in_ready",  longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", longint'(bus.out_valid), 0);
        chk("post_rst_rgb", longint'({bus.out_r, bus.out_g, bus.out_b}), 0);
        chk("post_rst_last", longint'(bus.out_last), 0);
        chk("post_rst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Directed values at full rate, latency checked
        or_mode   = 0;
        check_lat = 1'b1;
        send(128, 128, 128, 0, 0);
        send(100, 128, 200, 0, 0);
        send(0,   0,   0,   0, 0);
        send(255, 255, 255, 0, 1);
        send(128, 128, 0,   0, 0);
        send(128, 128, 255, 0, 0);
        send(16,  128, 128, 1, 0);
        send(235, 128, 128, 1, 1);
        send(16,  16,  240, 1, 0);
        send(235, 240, 16,  1, 0);
        for (int i = 0; i < 8; i++)
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), i % 2, int'($urandom_range(0, 1)));
        drain();

        // Random beats with random gaps and ~50% backpressure
        check_lat = 1'b0;
        or_mode   = 1;
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        or_mode = 0;
        drain();

        // Fill all three stages against a stalled sink, then reset asynchronously
        or_mode = 2;
        idle(1);
        send(50, 60, 70, 0, 1);
        send(80, 90, 100, 1, 0);
        send(200, 30, 220, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", longint'(bus.out_valid), 0);
        chk("async_rst_rgb", longint'({bus.out_r, bus.out_g, bus.out_b}), 0);
        chk("async_rst_last", longint'(bus.out_last), 0);
        chk("async_rst_in_ready", longint'(bus.in_ready), 1);
        idle(2);
        or_mode = 0;
        rst     = 1'b0;
        idle(2);
        check_lat = 1'b1;
        send(180, 100, 150, 1, 1);
        drain();
        send(30, 200, 60, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, expected end of test", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
